rv32i_program_counter: RTL and testbench

- Program counter register for the rv32i single-core datapath; it supplies the fetch address to instruction memory every cycle.
- Each clock it advances by PC_STEP, or takes a PC-relative branch/jump (current PC + offset), or holds when stalled.
- It also provides PC+4 combinationally, used as the link/return address by the writeback mux.

---
 rtl/rv32i_program_counter_if.sv | 48 ++++
 rtl/rv32i_program_counter.sv | 57 +++++
 tb/tb_rv32i_program_counter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rv32i_program_counter_if.sv
// Fetch-side bus of the rv32i program counter.
// The datapath (master) drives the stall/branch controls and the branch
// offset; the program counter (slave) returns the fetch address, the link
// address and the misaligned-target flag.
// With PC_NEXT_PORT_EN defined the bus also carries pc_next, the address
// the PC will load at the coming edge, for next-address prefetch.
// DATA_WIDTH must match the DATA_WIDTH of the program counter it connects to.
interface rv32i_program_counter_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  stall;
  logic                  pc_select;
  logic [DATA_WIDTH-1:0] pc_in;
  logic [DATA_WIDTH-1:0] pc_out;
  logic [DATA_WIDTH-1:0] pc_plus_4;
  logic                  misaligned;
`ifdef PC_NEXT_PORT_EN
  logic [DATA_WIDTH-1:0] pc_next;
`endif

  // Datapath side: steers the PC and consumes the addresses.
  modport master (
    output stall,
    output pc_select,
    output pc_in,
    input  pc_out,
    input  pc_plus_4,
`ifdef PC_NEXT_PORT_EN
    input  pc_next,
`endif
    input  misaligned
  );

  // Program counter side: owns the PC register.
  modport slave (
    input  stall,
    input  pc_select,
    input  pc_in,
    output pc_out,
    output pc_plus_4,
`ifdef PC_NEXT_PORT_EN
    output pc_next,
`endif
    output misaligned
  );

endinterface

// File: rtl/rv32i_program_counter.sv
// Program counter for the rv32i single-core datapath.
// Holds the fetch address in one register. Each cycle it either holds
// (stall), takes a PC-relative branch (pc_out + pc_in), or steps by PC_STEP.
// pc_plus_4 is the link/return address for the writeback mux.
// misaligned is advisory: the unaligned target is still loaded, and trapping
// is handled elsewhere.
// All arithmetic is modulo 2^DATA_WIDTH, so negative offsets and the wrap
// past the top of the address space need no special handling.
// Optional feature macro: PC_NEXT_PORT_EN exposes pc_next, the value the
// register will take at the next rising edge.
// rst is synchronous and active-low.
module rv32i_program_counter #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] BOOT_ADDR  = '0,
  parameter logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4)
) (
  input logic                    clk,
  input logic                    rst,
  rv32i_program_counter_if.slave bus
);

  logic [DATA_WIDTH-1:0] r_pcQ;
  logic [DATA_WIDTH-1:0] w_branchTarget;
  logic [DATA_WIDTH-1:0] w_seqTarget;
  logic [DATA_WIDTH-1:0] w_pcAdvance;

  // Candidate next addresses; the branch target is selected only when
  // pc_select is high, so pc_in cannot reach the register otherwise.
  always_comb begin
    w_branchTarget = r_pcQ + bus.pc_in;
    w_seqTarget    = r_pcQ + PC_STEP;
    w_pcAdvance    = w_seqTarget;
    if (bus.stall) begin
      w_pcAdvance = r_pcQ;
    end else if (bus.pc_select) begin
      w_pcAdvance = w_branchTarget;
    end
  end

  // PC register: reset wins over stall and branch in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pcQ <= BOOT_ADDR;
    end else begin
      r_pcQ <= w_pcAdvance;
    end
  end

  assign bus.pc_out     = r_pcQ;
  assign bus.pc_plus_4  = w_seqTarget;
  assign bus.misaligned = bus.pc_select && (w_branchTarget[1:0] != 2'b00);

`ifdef PC_NEXT_PORT_EN
  assign bus.pc_next = (!rst) ? BOOT_ADDR : w_pcAdvance;
`endif

endmodule

// File: tb/tb_rv32i_program_counter.sv
// Self-checking bench for rv32i_program_counter.
// Expected PC values come from a small reference model and are queued when
// stimulus is driven, then popped and compared once the edge has passed.
// Combinational outputs (pc_plus_4, misaligned, pc_next) are checked while
// the stimulus is held, before the edge.
module tb_rv32i_program_counter;

  localparam logic [31:0] BOOT = 32'h0000_0000;
  localparam logic [31:0] STEP = 32'd4;

  logic clk;
  logic rst;

  rv32i_program_counter_if #(.DATA_WIDTH(32)) pcIf ();

  rv32i_program_counter #(
    .DATA_WIDTH(32),
    .BOOT_ADDR (BOOT),
    .PC_STEP   (STEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(pcIf)
  );

  int checkCount;
  int failCount;
  logic [31:0] expQ[$];
  logic [31:0] pcModel;
  bit modelValid;

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of controls, checks the combinational outputs, then
  // checks the registered PC after the edge against the queued model value.
  task automatic applyStimulus(input string tag, input logic rstV, input logic stallV,
                               input logic selV, input logic [31:0] offV);
    logic [31:0] nextPc;
    logic [31:0] target;
    logic [31:0] got;
    logic        expMis;
    rst            = rstV;
    pcIf.stall     = stallV;
    pcIf.pc_select = selV;
    pcIf.pc_in     = offV;

    target = pcModel + offV;
    if (!rstV)       nextPc = BOOT;
    else if (stallV) nextPc = pcModel;
    else if (selV)   nextPc = target;
    else             nextPc = pcModel + STEP;
    expQ.push_back(nextPc);

    #1;
    if (modelValid) begin
      expMis = selV && (target[1:0] != 2'b00);
      checkOutput({tag, "_plus4"}, pcIf.pc_plus_4, pcModel + STEP);
      checkOutput({tag, "_misaligned"}, {31'b0, pcIf.misaligned}, {31'b0, expMis});
    end
`ifdef PC_NEXT_PORT_EN
    if (modelValid || !rstV) begin
      checkOutput({tag, "_next"}, pcIf.pc_next, nextPc);
    end
`endif

    @(posedge clk);
    #1;
    got = expQ.pop_front();
    checkOutput({tag, "_pc"}, pcIf.pc_out, got);
    pcModel = nextPc;
    if (!rstV) modelValid = 1'b1;
  endtask

  initial begin
    checkCount     = 0;
    failCount      = 0;
    modelValid     = 1'b0;
    pcModel        = '0;
    rst            = 1'b0;
    pcIf.stall     = 1'b1;
    pcIf.pc_select = 1'b0;
    pcIf.pc_in     = '0;

    // Reset with stall held, then normal stepping.
    applyStimulus("reset", 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus("step0", 1'b1, 1'b0, 1'b0, $urandom);
    // Forward branch then sequential step.
    applyStimulus("brFwd", 1'b1, 1'b0, 1'b1, 32'h10);
    applyStimulus("step1", 1'b1, 1'b0, 1'b0, $urandom);
    // Stall beats select.
    applyStimulus("stallSel", 1'b1, 1'b1, 1'b1, 32'h40);
    // Backward branch through two's-complement wrap.
    applyStimulus("brBack", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
    applyStimulus("step2", 1'b1, 1'b0, 1'b0, 32'h0);
    // Jump to top of address space and step across the wrap.
    applyStimulus("brTop", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFE8);
    applyStimulus("wrap", 1'b1, 1'b0, 1'b0, 32'h0);
    // Misaligned target is flagged but still loaded.
    applyStimulus("misBr", 1'b1, 1'b0, 1'b1, 32'h2);
    // Misaligned flag is not gated by stall.
    applyStimulus("misStall", 1'b1, 1'b1, 1'b1, 32'h1);
    // Held select takes a branch every cycle.
    applyStimulus("held0", 1'b1, 1'b0, 1'b1, 32'h2);
    applyStimulus("held1", 1'b1, 1'b0, 1'b1, 32'h8);
    // Reset overrides stall and select.
    applyStimulus("rstMid", 1'b0, 1'b1, 1'b1, 32'h100);
    applyStimulus("step3", 1'b1, 1'b0, 1'b0, $urandom);

    // Random mix of controls and offsets.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] off;
      off = $urandom;
      if ($urandom_range(0, 1) == 0) off = off & 32'hFFFF_FFFC;
      applyStimulus("rand", ($urandom_range(0, 15) != 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 2) == 0), off);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
